reset_button_conditioner: RTL and testbench
===========================================

// Module: reset_button_conditioner
// PURPOSE
//  Turns the raw DE0 pushbutton (KEY, active-low, bouncy, asynchronous) into a clean reset request.
//  The request drives reset_in of the reset-flow stage, which adds the power-up delay.
//  Synchronises, debounces, optionally requires a long press, then emits a fixed-length pulse.
//  Emits one pulse per press.
// PARAMETERS
//  CNT_W           30          counter width; must hold max(DEBOUNCE_CYCLES, HOLD_CYCLES, PULSE_CYCLES)
//  DEBOUNCE_CYCLES 1_000_000   consecutive stable cycles needed to accept a level change (20 ms @ 50 MHz); >=1
//  HOLD_CYCLES     50_000_000  long-press length before firing (1 s @ 50 MHz); >=1; used only with RESET_COND_HOLD_EN
//  PULSE_CYCLES    16          reset_req high time in cycles; >=1
// PORTS
//  clock      in   1  system clock, 50 MHz
//  reset      in   1  synchronous, active-high; clears all state
//  key_n      in   1  raw button, 0 = pressed, asynchronous to clock
//  pressed    out  1  debounced button level, 1 = pressed
//  holding    out  1  high while a long press is being timed (always 0 without RESET_COND_HOLD_EN)
//  reset_req  out  1  clean reset request, high for exactly PULSE_CYCLES cycles per accepted press
// BEHAVIOUR
//  - Clocking and reset
//    - All outputs are registered.
//    - On reset: sync flops=0 (released), counters=0, state=IDLE, pressed=0, holding=0, reset_req=0.
//    - Reset asserted mid-pulse forces reset_req=0 at the next edge.
//    - After reset is released, a button still held must debounce again from scratch.
//  - Synchroniser
//    - key_s = ~key_n through 2 flops; 2 cycles latency.
//  - Debounce
//    - db_cnt increments each cycle while key_s != pressed; cleared whenever key_s == pressed.
//    - When db_cnt == DEBOUNCE_CYCLES-1 and key_s != pressed: pressed <= key_s, db_cnt <= 0.
//    - Net: a clean edge on key_n shows on pressed 2+DEBOUNCE_CYCLES edges later.
//    - A glitch shorter than DEBOUNCE_CYCLES never changes pressed.
//  - FSM states: IDLE, HOLD, FIRE, WAIT_REL
//    - IDLE:
//      - pressed==1 -> HOLD if RESET_COND_HOLD_EN is defined, else FIRE.
//      - Entering HOLD or FIRE clears the counter.
//    - HOLD:
//      - holding=1; hold_cnt increments while pressed.
//      - pressed==0 before the count completes -> IDLE, no pulse.
//      - hold_cnt == HOLD_CYCLES-1 -> FIRE.
//    - FIRE:
//      - reset_req=1, registered; high from the first cycle the FSM is in FIRE.
//      - Lasts exactly PULSE_CYCLES cycles, then -> WAIT_REL.
//      - Releasing the button during FIRE does not shorten the pulse.
//    - WAIT_REL:
//      - reset_req=0; pressed==0 -> IDLE.
//      - Holding the button forever yields exactly one pulse.
//  - Latency, no hold: reset_req rises 1 edge after pressed rises.
//  - Counters are compared with ==, never wrap in normal operation, and are cleared on every state entry.
//  - Simultaneous events: a release in the same cycle hold_cnt reaches HOLD_CYCLES-1 counts as a release (-> IDLE, no pulse).
// CONFIGURATION
//  - RESET_COND_HOLD_EN defined:
//    - The long-press gate (HOLD state) is compiled in.
//    - A press must stay debounced-high for HOLD_CYCLES before firing.
//  - RESET_COND_HOLD_EN undefined:
//    - The HOLD state and hold_cnt logic are removed.
//    - holding is tied to 0.
//    - IDLE goes straight to FIRE.
// TESTING  (bench params: DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, PULSE_CYCLES=3)
//  1. reset=1 for 2 cycles with key_n=0 -> pressed, holding, reset_req all 0; after release, pressed=1 only 6 edges later.
//  2. No HOLD_EN: key_n 1->0 at edge 0 and held -> pressed=1 at edge 6, reset_req=1 at edges 7-9, 0 from edge 10 while still held.
//  3. Bounce: key_n low for 3 cycles, high for 2, then low and held -> pressed rises 6 edges after the final fall; exactly one pulse.
//  4. HOLD_EN: press held -> holding=1 from edge 7, reset_req high for 3 cycles starting 10 cycles later; release after 5 hold cycles -> holding drops, no pulse.
//  5. Release during FIRE (no HOLD_EN) -> reset_req stays high for all 3 cycles; a new press after release debounces and pulses again.
//  6. Assert reset on the 2nd reset_req cycle -> reset_req=0 at the next edge; FSM=IDLE; no pulse until the button is re-debounced.

Source files
------------

// File: rtl/reset_button_conditioner.sv
// Purpose: turns the raw active-low bouncy KEY into a clean fixed-length reset request.
// Latency: key_n edge -> pressed in 2+DEBOUNCE_CYCLES edges; pressed -> reset_req in 1 edge (plus HOLD_CYCLES with long press).
// Backpressure: none; key_n is sampled every cycle and reset_req is a free-running pulse.
// Optional long-press gate: define RESET_COND_HOLD_EN to compile in the HOLD state.
module reset_button_conditioner #(
  parameter int CNT_W           = 30,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int PULSE_CYCLES    = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic pressed,
  output logic holding,
  output logic reset_req
);

  typedef enum logic [1:0] {IDLE, HOLD, FIRE, WAIT_REL} state_t;

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
`ifdef RESET_COND_HOLD_EN
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
`endif

  // Every cycle count must be at least one, otherwise the terminal compares never match.
  if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || PULSE_CYCLES < 1) begin : g_bad_params
    $error("reset_button_conditioner: cycle-count parameters must be >= 1");
  end

  logic             key_meta;
  logic             key_s;
  logic [CNT_W-1:0] db_cnt;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Two-flop synchroniser; inverts so key_s is 1 while the button is held.
  always_ff @(posedge clock) begin
    if (reset) begin
      key_meta <= 1'b0;
      key_s    <= 1'b0;
    end else begin
      key_meta <= ~key_n;
      key_s    <= key_meta;
    end
  end

  // Debounce: accept a new level only after it has been stable for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      db_cnt  <= '0;
      pressed <= 1'b0;
    end else if (key_s != pressed) begin
      if (db_cnt == DB_LAST) begin
        pressed <= key_s;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Next-state logic; the shared counter is cleared on every state entry.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (pressed) begin
`ifdef RESET_COND_HOLD_EN
          state_nxt = HOLD;
`else
          state_nxt = FIRE;
`endif
          cnt_nxt = '0;
        end
      end
`ifdef RESET_COND_HOLD_EN
      HOLD: begin
        // A release wins over a simultaneous terminal count.
        if (!pressed) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = FIRE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`endif
      FIRE: begin
        // Pulse length is fixed; the button level is ignored here.
        if (cnt == PULSE_LAST) begin
          state_nxt = WAIT_REL;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_REL: begin
        if (!pressed) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State register with outputs registered from the next state so they align with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      reset_req <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      reset_req <= (state_nxt == FIRE);
    end
  end

`ifdef RESET_COND_HOLD_EN
  // holding mirrors residency in HOLD, registered like reset_req.
  always_ff @(posedge clock) begin
    if (reset) begin
      holding <= 1'b0;
    end else begin
      holding <= (state_nxt == HOLD);
    end
  end
`else
  assign holding = 1'b0;
`endif

endmodule

// File: tb/tb_reset_button_conditioner.sv
// Bench for reset_button_conditioner: directed table plus random key/reset traffic
// checked every cycle against a window-based reference model of the press rules.
module tb_reset_button_conditioner;

  localparam int DEB   = 4;
  localparam int HOLD  = 10;
  localparam int PULSE = 3;
  localparam int MAXE  = 6000;

  logic clock = 1'b0;
  logic reset;
  logic key_n;
  logic pressed;
  logic holding;
  logic reset_req;

  initial forever #5 clock = ~clock;

  reset_button_conditioner #(
    .CNT_W(8),
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES(HOLD),
    .PULSE_CYCLES(PULSE)
  ) dut (
    .clock(clock),
    .reset(reset),
    .key_n(key_n),
    .pressed(pressed),
    .holding(holding),
    .reset_req(reset_req)
  );

  typedef struct {
    bit kn;
    bit rst;
    int n;
    bit p;
    bit h;
    bit r;
  } vec_t;

  vec_t tbl[$];

  // Per-edge history: inputs seen at edge k and the model's debounced level after edge k.
  bit kn_a[MAXE];
  bit rs_a[MAXE];
  bit p_a[MAXE];
  bit rise_a[MAXE];
  int e = 0;
  int last_change = 0;
  int last_rst = 0;
  int n_vec = 0;
  int n_bad = 0;
  bit exp_p, exp_h, exp_r;

  task automatic chk(input string name, input logic got, input bit expv);
    n_vec++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s edge=%0d got=%b expected=%b", name, e, got, expv);
    end
  endtask

  task automatic add(input bit kn, input bit rst, input int n, input bit p, input bit h, input bit r);
    vec_t v;
    v.kn = kn; v.rst = rst; v.n = n; v.p = p; v.h = h; v.r = r;
    tbl.push_back(v);
  endtask

  // Synchronised button level used at edge k: key_n from two edges earlier, zero if reset intervened.
  function automatic bit s_at(input int k);
    if (k < 2) return 1'b0;
    if (rs_a[k-1] || rs_a[k-2]) return 1'b0;
    return !kn_a[k-2];
  endfunction

  function automatic bit high_span(input int a, input int b);
    for (int k = a; k <= b; k++) if (!p_a[k]) return 1'b0;
    return 1'b1;
  endfunction

  // Expected outputs after edge k: debounced level flips once DEB consecutive samples disagree
  // with it; pulses/holding are time windows relative to each accepted rising edge.
  task automatic model_step(input int k);
    bit p;
    bit all;
    int r;
    if (rs_a[k]) begin
      p = 1'b0;
      last_change = k;
      last_rst = k;
    end else begin
      p = p_a[k-1];
      if (k - last_change >= DEB) begin
        all = 1'b1;
        for (int j = 0; j < DEB; j++) if (s_at(k - j) == p_a[k-1]) all = 1'b0;
        if (all) begin
          p = !p;
          last_change = k;
        end
      end
    end
    p_a[k]    = p;
    rise_a[k] = p && !p_a[k-1];
    exp_p = p;
    exp_h = 1'b0;
    exp_r = 1'b0;
`ifdef RESET_COND_HOLD_EN
    for (int d = 1; d <= HOLD; d++) begin
      r = k - d;
      if (r >= 1 && rise_a[r] && last_rst <= r && high_span(r, k - 1)) exp_h = 1'b1;
    end
    for (int d = HOLD + 1; d <= HOLD + PULSE; d++) begin
      r = k - d;
      if (r >= 1 && rise_a[r] && last_rst <= r && high_span(r, r + HOLD)) exp_r = 1'b1;
    end
`else
    for (int d = 1; d <= PULSE; d++) begin
      r = k - d;
      if (r >= 1 && rise_a[r] && last_rst <= r) exp_r = 1'b1;
    end
`endif
  endtask

  // One clock: drive, let the edge happen, then check on the falling edge.
  task automatic tick(input bit kn, input bit rst);
    key_n = kn;
    reset = rst;
    @(posedge clock);
    e++;
    if (e >= MAXE) begin
      $display("FAIL history_overflow edge=%0d limit=%0d", e, MAXE);
      $fatal(1, "history overflow");
    end
    kn_a[e] = kn;
    rs_a[e] = rst;
    @(negedge clock);
    model_step(e);
    chk("model_pressed", pressed, exp_p);
    chk("model_holding", holding, exp_h);
    chk("model_reset_req", reset_req, exp_r);
  endtask

  initial begin
    bit lvl;
    bit rst;
    int run;
    rs_a[0] = 1'b1;
    p_a[0]  = 1'b0;
    key_n = 1'b1;
    reset = 1'b1;

`ifdef RESET_COND_HOLD_EN
    add(0,1,2, 0,0,0);
    add(0,0,5, 0,0,0); add(0,0,1, 1,0,0);
    add(0,0,1, 1,1,0); add(0,0,9, 1,1,0);
    add(0,0,1, 1,0,1); add(0,0,2, 1,0,1); add(0,0,1, 1,0,0); add(0,0,4, 1,0,0);
    add(1,0,6, 0,0,0); add(1,0,2, 0,0,0);
    add(0,0,6, 1,0,0); add(0,0,1, 1,1,0);
    add(1,0,5, 1,1,0); add(1,0,1, 0,1,0); add(1,0,1, 0,0,0); add(1,0,12, 0,0,0);
`else
    // Reset held with the key down, then re-debounce and a single pulse.
    add(0,1,2, 0,0,0);
    add(0,0,5, 0,0,0); add(0,0,1, 1,0,0);
    add(0,0,1, 1,0,1); add(0,0,2, 1,0,1); add(0,0,1, 1,0,0); add(0,0,5, 1,0,0);
    add(1,0,5, 1,0,0); add(1,0,1, 0,0,0); add(1,0,3, 0,0,0);
    // Bouncy press.
    add(0,0,3, 0,0,0); add(1,0,2, 0,0,0); add(0,0,5, 0,0,0); add(0,0,1, 1,0,0);
    add(0,0,3, 1,0,1); add(0,0,6, 1,0,0);
    add(1,0,6, 0,0,0); add(1,0,2, 0,0,0);
    // Release during the pulse, then a fresh press.
    add(0,0,6, 1,0,0); add(0,0,1, 1,0,1); add(1,0,2, 1,0,1); add(1,0,1, 1,0,0);
    add(1,0,2, 1,0,0); add(1,0,1, 0,0,0); add(1,0,2, 0,0,0);
    add(0,0,6, 1,0,0); add(0,0,3, 1,0,1); add(0,0,1, 1,0,0);
    // Reset on the second pulse cycle while the key stays down.
    add(1,0,6, 0,0,0); add(1,0,2, 0,0,0);
    add(0,0,6, 1,0,0); add(0,0,1, 1,0,1); add(0,1,1, 0,0,0);
    add(0,0,5, 0,0,0); add(0,0,1, 1,0,0); add(0,0,1, 1,0,1); add(0,0,2, 1,0,1);
    add(0,0,1, 1,0,0);
`endif

    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].n; c++) tick(tbl[i].kn, tbl[i].rst);
      chk("tbl_pressed", pressed, tbl[i].p);
      chk("tbl_holding", holding, tbl[i].h);
      chk("tbl_reset_req", reset_req, tbl[i].r);
    end

    // Random bursts of bounce and long presses with occasional resets.
    for (int c = 0; c < 2500; ) begin
      run = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : $urandom_range(1, 6);
      lvl = 1'($urandom_range(0, 1));
      for (int j = 0; j < run; j++) begin
        rst = ($urandom_range(0, 299) == 0);
        tick(lvl, rst);
        c++;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
